// File: rtl/fp_load_stream.sv
// fp_load_stream: DEPTH-entry FIFO front-end for the sqrt datapath.
// Accepts packed FP words {sign, exp, mant} through valid/ready (EDGE_TRIG=0)
// or the legacy capture-on-rising-enable mode (EDGE_TRIG=1). The head entry
// is presented unpacked, with its significand and class flags.
module fp_load_stream #(
  parameter  int EXP_W     = 5,
  parameter  int MANT_W    = 10,
  parameter  int DEPTH     = 4,
  parameter  int EDGE_TRIG = 0,
  localparam int W         = 1 + EXP_W + MANT_W,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [W-1:0]      in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [MANT_W-1:0] mant,
  output logic [MANT_W:0]   sig,
  output logic              is_zero,
  output logic              is_sub,
  output logic              is_inf,
  output logic              is_nan,
  output logic [CW-1:0]     count,
  output logic              ovf
);

  // Edge mode only captures on the first cycle of an in_valid run.
  localparam logic EDGE_MODE = (EDGE_TRIG != 0);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_prev_valid;
  logic          r_ovf;

  logic          w_full;
  logic          w_push_req;
  logic          w_push;
  logic          w_pop;
  logic [W-1:0]  w_head;
  logic          w_exp_zero;
  logic          w_exp_ones;
  logic          w_mant_zero;

  // in_ready depends only on registered occupancy, so a same-cycle pop never
  // opens the input and there is no out_ready -> in_ready path.
  assign w_full     = (r_count == CW'(DEPTH));
  assign in_ready   = ~w_full;
  assign out_valid  = (r_count != '0);
  assign w_push_req = in_valid & ~(EDGE_MODE & r_prev_valid);
  assign w_push     = w_push_req & ~w_full;
  assign w_pop      = out_valid & out_ready;

  // Occupancy, pointers, edge detector and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_prev_valid <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_count      <= r_count + CW'(w_push) - CW'(w_pop);
      r_prev_valid <= in_valid;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (EDGE_MODE && w_push_req && w_full) r_ovf <= 1'b1;
    end
  end

  // Storage slots; cleared on reset so the head outputs read zero afterwards.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    // Write slot gi when the write pointer addresses it.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_mem[gi] <= '0;
      end else if (w_push && (r_wr_ptr == AW'(gi))) begin
        r_mem[gi] <= in_data;
      end
    end
  end

  // Head unpacking and classification; flags are held low while empty.
  always_comb begin
    w_head      = r_mem[r_rd_ptr];
    sign        = w_head[W-1];
    exp         = w_head[W-2 -: EXP_W];
    mant        = w_head[MANT_W-1:0];
    w_exp_zero  = (exp == '0);
    w_exp_ones  = &exp;
    w_mant_zero = (mant == '0);
    sig         = {~w_exp_zero, mant};
    is_zero     = out_valid & w_exp_zero &  w_mant_zero;
    is_sub      = out_valid & w_exp_zero & ~w_mant_zero;
    is_inf      = out_valid & w_exp_ones &  w_mant_zero;
    is_nan      = out_valid & w_exp_ones & ~w_mant_zero;
  end

  assign count = r_count;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_fp_load_stream.sv
// Testbench for fp_load_stream: a stream-mode and an edge-mode instance,
// scoreboard queue for the stream instance, one task per scenario.
module tb_fp_load_stream;
  localparam int EXP_W  = 5;
  localparam int MANT_W = 10;
  localparam int DEPTH  = 4;
  localparam int W      = 16;
  localparam int CW     = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // stream-mode instance signals
  logic s_in_valid = 1'b0, s_out_ready = 1'b0;
  logic [W-1:0] s_in_data = '0;
  logic s_in_ready, s_out_valid, s_sign, s_is_zero, s_is_sub, s_is_inf, s_is_nan, s_ovf;
  logic [EXP_W-1:0] s_exp;
  logic [MANT_W-1:0] s_mant;
  logic [MANT_W:0] s_sig;
  logic [CW-1:0] s_count;

  // edge-mode instance signals
  logic e_in_valid = 1'b0, e_out_ready = 1'b0;
  logic [W-1:0] e_in_data = '0;
  logic e_in_ready, e_out_valid, e_sign, e_is_zero, e_is_sub, e_is_inf, e_is_nan, e_ovf;
  logic [EXP_W-1:0] e_exp;
  logic [MANT_W-1:0] e_mant;
  logic [MANT_W:0] e_sig;
  logic [CW-1:0] e_count;

  fp_load_stream #(.EXP_W(EXP_W), .MANT_W(MANT_W), .DEPTH(DEPTH), .EDGE_TRIG(0)) u_stream (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .sign(s_sign), .exp(s_exp), .mant(s_mant),
    .sig(s_sig), .is_zero(s_is_zero), .is_sub(s_is_sub), .is_inf(s_is_inf), .is_nan(s_is_nan),
    .count(s_count), .ovf(s_ovf));

  fp_load_stream #(.EXP_W(EXP_W), .MANT_W(MANT_W), .DEPTH(DEPTH), .EDGE_TRIG(1)) u_edge (
    .clk(clk), .rst(rst), .in_valid(e_in_valid), .in_data(e_in_data), .in_ready(e_in_ready),
    .out_valid(e_out_valid), .out_ready(e_out_ready), .sign(e_sign), .exp(e_exp), .mant(e_mant),
    .sig(e_sig), .is_zero(e_is_zero), .is_sub(e_is_sub), .is_inf(e_is_inf), .is_nan(e_is_nan),
    .count(e_count), .ovf(e_ovf));

  int n_total = 0;
  int n_pass  = 0;

  // scoreboard for the stream instance
  logic [W-1:0] q[$];
  int mcount = 0;
  bit obs_pop;
  logic [W-1:0] obs_word, exp_word;
  logic [MANT_W:0] obs_sig;
  logic [3:0] obs_cls;

  // One stream cycle: predict push/pop, snapshot a popped head, advance clock.
  task automatic step();
    bit push, pop;
    pop  = s_out_ready && (mcount > 0);
    push = s_in_valid && (mcount < DEPTH);
    obs_pop = pop;
    if (pop) begin
      obs_word = {s_sign, s_exp, s_mant};
      obs_sig  = s_sig;
      obs_cls  = {s_is_zero, s_is_sub, s_is_inf, s_is_nan};
      exp_word = q.pop_front();
      $display("txn pop word=%h expected=%h", obs_word, exp_word);
    end
    if (push) q.push_back(s_in_data);
    mcount = mcount + int'(push) - int'(pop);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic estep();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++; if (s_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", s_count); else n_pass++;
    n_total++; if (s_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", s_out_valid); else n_pass++;
    n_total++; if (s_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", s_in_ready); else n_pass++;
    n_total++; if ({s_sign, s_exp, s_mant, s_sig} !== 27'd0) $display("FAIL reset_data: got %h want 0", {s_sign, s_exp, s_mant, s_sig}); else n_pass++;
    n_total++; if ({s_is_zero, s_is_sub, s_is_inf, s_is_nan} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {s_is_zero, s_is_sub, s_is_inf, s_is_nan}); else n_pass++;
    n_total++; if ({s_ovf, e_ovf, e_count} !== 5'd0) $display("FAIL reset_edge: got %b want 0", {s_ovf, e_ovf, e_count}); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (s_in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", s_in_ready); else n_pass++;
  endtask

  task automatic test_basic();
    s_out_ready = 1'b1;
    s_in_valid = 1'b1; s_in_data = 16'h3C00;
    step();
    n_total++; if (s_out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", s_out_valid); else n_pass++;
    n_total++; if ({s_sign, s_exp, s_mant} !== {1'b0, 5'h0F, 10'h000}) $display("FAIL basic_fields: got %b/%h/%h want 0/0f/000", s_sign, s_exp, s_mant); else n_pass++;
    n_total++; if (s_sig !== 11'h400) $display("FAIL basic_sig: got %h want 400", s_sig); else n_pass++;
    n_total++; if ({s_is_zero, s_is_sub, s_is_inf, s_is_nan} !== 4'b0) $display("FAIL basic_flags: got %b want 0000", {s_is_zero, s_is_sub, s_is_inf, s_is_nan}); else n_pass++;
    s_in_valid = 1'b0;
    step();
    n_total++; if (obs_word !== exp_word) $display("FAIL basic_pop: got %h want %h", obs_word, exp_word); else n_pass++;
    n_total++; if (s_count !== 3'd0) $display("FAIL basic_count: got %0d want 0", s_count); else n_pass++;
  endtask

  task automatic test_classes();
    logic [W-1:0]    words [4] = '{16'h8000, 16'h0001, 16'h7C00, 16'h7E00};
    logic [3:0]      cls   [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [MANT_W:0] sigs  [4] = '{11'h000, 11'h001, 11'h400, 11'h600};
    int npop = 0;
    s_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_in_valid = (i < 4);
      s_in_data  = (i < 4) ? words[i] : 16'h0;
      step();
      if (obs_pop && npop < 4) begin
        n_total++; if (obs_word !== exp_word) $display("FAIL class_word: got %h want %h", obs_word, exp_word); else n_pass++;
        n_total++; if (obs_cls !== cls[npop]) $display("FAIL class_flags: word %h got %b want %b", obs_word, obs_cls, cls[npop]); else n_pass++;
        n_total++; if (obs_sig !== sigs[npop]) $display("FAIL class_sig: word %h got %h want %h", obs_word, obs_sig, sigs[npop]); else n_pass++;
        npop++;
      end
    end
    n_total++; if (npop !== 4 || s_count !== 3'd0) $display("FAIL class_drain: got pops=%0d count=%0d want 4/0", npop, s_count); else n_pass++;
  endtask

  task automatic test_full();
    int k = 1;
    int nexp = 1;
    s_out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bit acc;
      s_in_valid = 1'b1; s_in_data = W'(k);
      acc = (mcount < DEPTH);
      step();
      if (acc) k++;
    end
    n_total++; if (s_count !== 3'd4) $display("FAIL full_count: got %0d want 4", s_count); else n_pass++;
    n_total++; if (s_in_ready !== 1'b0) $display("FAIL full_in_ready: got %b want 0", s_in_ready); else n_pass++;
    s_out_ready = 1'b1;
    for (int c = 0; c < 30 && (k <= 6 || mcount > 0); c++) begin
      bit acc;
      s_in_valid = (k <= 6); s_in_data = W'(k);
      acc = s_in_valid && (mcount < DEPTH);
      step();
      if (acc) k++;
      if (obs_pop) begin
        n_total++; if (obs_word !== exp_word || obs_word !== W'(nexp)) $display("FAIL full_order: got %h want %h", obs_word, W'(nexp)); else n_pass++;
        nexp++;
      end
    end
    s_in_valid = 1'b0;
    n_total++; if (nexp !== 7 || s_count !== 3'd0) $display("FAIL full_drain: got popped=%0d count=%0d want 6/0", nexp - 1, s_count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nexp = 16'h0100;
    s_out_ready = 1'b0;
    s_in_valid = 1'b1;
    s_in_data = 16'h0100; step();
    s_in_data = 16'h0101; step();
    n_total++; if (s_count !== 3'd2) $display("FAIL b2b_prefill: got %0d want 2", s_count); else n_pass++;
    s_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_in_data = W'(16'h0102 + i);
      step();
      n_total++; if (s_count !== 3'd2) $display("FAIL b2b_count: cycle %0d got %0d want 2", i, s_count); else n_pass++;
      if (obs_pop) begin
        n_total++; if (obs_word !== exp_word || obs_word !== W'(nexp)) $display("FAIL b2b_order: got %h want %h", obs_word, W'(nexp)); else n_pass++;
        nexp++;
      end
    end
    s_in_valid = 1'b0;
    for (int c = 0; c < 10 && mcount > 0; c++) begin
      step();
      if (obs_pop) begin
        n_total++; if (obs_word !== exp_word || obs_word !== W'(nexp)) $display("FAIL b2b_drain: got %h want %h", obs_word, W'(nexp)); else n_pass++;
        nexp++;
      end
    end
    n_total++; if (s_count !== 3'd0 || nexp !== 16'h010C) $display("FAIL b2b_end: got count=%0d next=%h want 0/010c", s_count, nexp); else n_pass++;
  endtask

  task automatic test_edge();
    logic [W-1:0] eq [4] = '{16'h4000, 16'h4100, 16'h4101, 16'h4102};
    e_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e_in_valid = 1'b1; e_in_data = W'(16'h4000 + i);
      estep();
    end
    n_total++; if (e_count !== 3'd1) $display("FAIL edge_hold_count: got %0d want 1", e_count); else n_pass++;
    n_total++; if ({e_sign, e_exp, e_mant} !== 16'h4000) $display("FAIL edge_hold_word: got %h want 4000", {e_sign, e_exp, e_mant}); else n_pass++;
    e_in_valid = 1'b0; estep();
    for (int p = 0; p < 3; p++) begin
      e_in_valid = 1'b1; e_in_data = W'(16'h4100 + p); estep();
      e_in_valid = 1'b0; estep();
    end
    n_total++; if (e_count !== 3'd4 || e_ovf !== 1'b0) $display("FAIL edge_fill: got count=%0d ovf=%b want 4/0", e_count, e_ovf); else n_pass++;
    e_in_valid = 1'b1; e_in_data = 16'h4200; estep();
    e_in_valid = 1'b0; estep();
    n_total++; if (e_count !== 3'd4 || e_ovf !== 1'b1) $display("FAIL edge_ovf: got count=%0d ovf=%b want 4/1", e_count, e_ovf); else n_pass++;
    e_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_total++; if ({e_sign, e_exp, e_mant} !== eq[i]) $display("FAIL edge_order: got %h want %h", {e_sign, e_exp, e_mant}, eq[i]); else n_pass++;
      $display("txn edge pop word=%h", {e_sign, e_exp, e_mant});
      estep();
    end
    e_out_ready = 1'b0;
    n_total++; if (e_count !== 3'd0 || e_ovf !== 1'b1) $display("FAIL edge_sticky: got count=%0d ovf=%b want 0/1", e_count, e_ovf); else n_pass++;
  endtask

  task automatic test_reset_mid();
    s_out_ready = 1'b0;
    s_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_in_data = W'(16'h5000 + i);
      step();
    end
    n_total++; if (s_count !== 3'd3) $display("FAIL mid_prefill: got %0d want 3", s_count); else n_pass++;
    rst = 1'b1;
    s_in_valid = 1'b1; s_in_data = 16'h1234; s_out_ready = 1'b1;
    e_in_valid = 1'b1; e_in_data = 16'h1234;
    estep();
    rst = 1'b0;
    s_in_valid = 1'b0; e_in_valid = 1'b0; s_out_ready = 1'b0;
    q.delete(); mcount = 0;
    n_total++; if (s_count !== 3'd0 || s_out_valid !== 1'b0) $display("FAIL mid_flush: got count=%0d valid=%b want 0/0", s_count, s_out_valid); else n_pass++;
    n_total++; if (s_in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b want 1", s_in_ready); else n_pass++;
    n_total++; if (e_ovf !== 1'b0) $display("FAIL mid_ovf_clear: got %b want 0", e_ovf); else n_pass++;
    n_total++; if ({s_sign, s_exp, s_mant} !== 16'h0) $display("FAIL mid_data: got %h want 0000", {s_sign, s_exp, s_mant}); else n_pass++;
    estep();
    n_total++; if (s_count !== 3'd0 || e_count !== 3'd0) $display("FAIL mid_no_capture: got s=%0d e=%0d want 0/0", s_count, e_count); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_classes();
    test_full();
    test_back_to_back();
    test_edge();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
